// File: rtl/wave_pkg.sv
// Shared definitions for the waveform sample generator: wave_sel encoding,
// default widths and the offset-binary mid-scale constant.
package wave_pkg;

  localparam int PHASE_W_DEF = 16;
  localparam int DATA_W_DEF  = 12;
  localparam int SINE_ADDR_W = 4;

  localparam logic [DATA_W_DEF-1:0] MID_SCALE_DEF = DATA_W_DEF'(1) << (DATA_W_DEF - 1);

  typedef enum logic [2:0] {
    WAVE_DC     = 3'd0,
    WAVE_SQUARE = 3'd1,
    WAVE_TRI    = 3'd2,
    WAVE_SAW    = 3'd3,
    WAVE_SINE   = 3'd4
  } wave_sel_e;

  function automatic logic [31:0] mid_scale(input int w);
    return 32'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine table with registered offset-binary output; the quadrant
// bits mirror the address and select the sign around mid-scale.
module sine_quarter_lut
  import wave_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld,
  input  logic [1:0]             quad,
  input  logic [SINE_ADDR_W-1:0] addr,
  output logic [DATA_W-1:0]      code
);

  localparam int PROD_W = 15 + DATA_W;
  localparam logic [DATA_W-1:0] MID = DATA_W'(mid_scale(DATA_W));
  localparam logic [DATA_W-1:0] AMP = MID - DATA_W'(1);

  // sin(i*pi/32) scaled to 32767, i = 0..15
  function automatic logic [14:0] quarter_sin(input logic [SINE_ADDR_W-1:0] idx);
    case (idx)
      4'd0:    return 15'd0;
      4'd1:    return 15'd3212;
      4'd2:    return 15'd6393;
      4'd3:    return 15'd9512;
      4'd4:    return 15'd12539;
      4'd5:    return 15'd15446;
      4'd6:    return 15'd18204;
      4'd7:    return 15'd20787;
      4'd8:    return 15'd23170;
      4'd9:    return 15'd25329;
      4'd10:   return 15'd27245;
      4'd11:   return 15'd28898;
      4'd12:   return 15'd30273;
      4'd13:   return 15'd31356;
      4'd14:   return 15'd32137;
      default: return 15'd32609;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] offset_binary(input logic [DATA_W-1:0] mag,
                                                      input logic neg);
    logic signed [DATA_W:0] mag_s;
    logic signed [DATA_W:0] sum_s;
    mag_s = signed'({1'b0, mag});
    sum_s = signed'({1'b0, MID}) + (neg ? -mag_s : mag_s);
    return DATA_W'(sum_s);
  endfunction

  logic [SINE_ADDR_W-1:0] idx;
  logic [PROD_W-1:0]      prod;
  logic [DATA_W-1:0]      mag;
  logic [DATA_W-1:0]      code_d;
  logic [DATA_W-1:0]      code_q;

  always_comb begin
    idx    = quad[0] ? ~addr : addr;
    prod   = PROD_W'(quarter_sin(idx)) * PROD_W'(AMP);
    mag    = DATA_W'(prod >> 15);
    code_d = ld ? offset_binary(mag, quad[1]) : code_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) code_q <= '0;
    else     code_q <= code_d;
  end

  assign code = code_q;

endmodule

// File: rtl/wave_sample_gen.sv
// Phase-accumulator waveform generator (DC/square/triangle/sawtooth/sine), 2-clock tick-to-sample latency.
// Optional sine table built only when WAVE_SAMPLE_GEN_SINE_EN is defined; otherwise sine requests give mid-scale.
module wave_sample_gen
  import wave_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               en,
  input  logic [2:0]         wave_sel,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [DATA_W-1:0]  dc_level,
  output logic [DATA_W-1:0]  sample,
  output logic               sample_valid
);

  localparam logic [DATA_W-1:0] MID = DATA_W'(mid_scale(DATA_W));

  function automatic logic [DATA_W-1:0] wave_code(input logic [PHASE_W-1:0] ph,
                                                  input logic [2:0]         sel,
                                                  input logic [DATA_W-1:0]  dc);
    case (sel)
      WAVE_SAW:    return ph[PHASE_W-1 -: DATA_W];
      WAVE_SQUARE: return {DATA_W{~ph[PHASE_W-1]}};
      WAVE_TRI:    return ph[PHASE_W-1] ? ~ph[PHASE_W-2 -: DATA_W] : ph[PHASE_W-2 -: DATA_W];
      WAVE_SINE:   return MID;
      default:     return dc;
    endcase
  endfunction

  logic [PHASE_W:0]   acc_sum;
  logic [PHASE_W-1:0] phase_d,   phase_q;
  logic [2:0]         act_sel_d, act_sel_q;
  logic [PHASE_W-1:0] act_inc_d, act_inc_q;
  logic               vld_p1_d,  vld_p1_q;
  logic               vld_p2_d,  vld_p2_q;
  logic [DATA_W-1:0]  sample_d,  sample_q;
  logic               ld_p2;

  // Stage p1: accumulate; selection/increment only change at a phase wrap while running
  always_comb begin
    acc_sum   = {1'b0, phase_q} + {1'b0, act_inc_q};
    phase_d   = phase_q;
    act_sel_d = act_sel_q;
    act_inc_d = act_inc_q;
    if (!en) begin
      phase_d   = '0;
      act_sel_d = wave_sel;
      act_inc_d = phase_inc;
    end else if (tick) begin
      phase_d = acc_sum[PHASE_W-1:0];
      if (acc_sum[PHASE_W]) begin
        act_sel_d = wave_sel;
        act_inc_d = phase_inc;
      end
    end
    vld_p1_d = tick & en;
  end

  // Stage p2: shape the updated phase into a sample code
  always_comb begin
    ld_p2    = vld_p1_q & en;
    vld_p2_d = ld_p2;
    sample_d = ld_p2 ? wave_code(phase_q, act_sel_q, dc_level) : sample_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= '0;
      act_sel_q <= WAVE_DC;
      act_inc_q <= '0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      sample_q  <= '0;
    end else begin
      phase_q   <= phase_d;
      act_sel_q <= act_sel_d;
      act_inc_q <= act_inc_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      sample_q  <= sample_d;
    end
  end

`ifdef WAVE_SAMPLE_GEN_SINE_EN
  logic              sine_sel_d, sine_sel_q;
  logic [DATA_W-1:0] sine_code;

  sine_quarter_lut #(
    .DATA_W(DATA_W)
  ) u_sine (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld_p2),
    .quad (phase_q[PHASE_W-1 -: 2]),
    .addr (phase_q[PHASE_W-3 -: SINE_ADDR_W]),
    .code (sine_code)
  );

  // The table register is a parallel p2 stage; this flag picks it for sine samples
  always_comb begin
    sine_sel_d = ld_p2 ? (act_sel_q == WAVE_SINE) : sine_sel_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sine_sel_q <= 1'b0;
    else     sine_sel_q <= sine_sel_d;
  end

  assign sample = sine_sel_q ? sine_code : sample_q;
`else
  assign sample = sample_q;
`endif

  assign sample_valid = vld_p2_q;

endmodule

// File: tb/tb_wave_sample_gen.sv
// Directed bench for wave_sample_gen; sine expectations follow WAVE_SAMPLE_GEN_SINE_EN.
module tb_wave_sample_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        en;
  logic [2:0]  wave_sel;
  logic [15:0] phase_inc;
  logic [11:0] dc_level;
  logic [11:0] sample;
  logic        sample_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wave_sample_gen #(
    .PHASE_W(16),
    .DATA_W (12)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .en           (en),
    .wave_sel     (wave_sel),
    .phase_inc    (phase_inc),
    .dc_level     (dc_level),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: one tick, then valid must appear exactly 2 clocks later.
  task automatic tick_chk(input string tag, input logic [11:0] exp);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check({tag, " vld+1"}, 32'(sample_valid), 32'd0);
    @(negedge clk);
    check({tag, " vld+2"}, 32'(sample_valid), 32'd1);
    check(tag, 32'(sample), 32'(exp));
  endtask

  task automatic setup(input logic [2:0] sel, input logic [15:0] inc);
    en        = 1'b0;
    wave_sel  = sel;
    phase_inc = inc;
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
  endtask

  logic [11:0] sq_exp  [4] = '{12'hFFF, 12'h000, 12'h000, 12'hFFF};
  logic [11:0] tri_exp [8] = '{12'h400, 12'h800, 12'hC00, 12'hFFF,
                               12'hBFF, 12'h7FF, 12'h3FF, 12'h000};
`ifdef WAVE_SAMPLE_GEN_SINE_EN
  logic [11:0] sin_exp [4] = '{12'hFF5, 12'h800, 12'h00B, 12'h800};
`else
  logic [11:0] sin_exp [4] = '{12'h800, 12'h800, 12'h800, 12'h800};
`endif

  initial begin
    rst       = 1'b1;
    tick      = 1'b0;
    en        = 1'b0;
    wave_sel  = 3'd0;
    phase_inc = 16'h0000;
    dc_level  = 12'h000;
    @(negedge clk);
    check("reset sample", 32'(sample), 32'd0);
    check("reset valid", 32'(sample_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    setup(3'd3, 16'h1000);
    for (int i = 1; i <= 17; i++) tick_chk($sformatf("saw%0d", i), 12'((i * 16'h100) & 12'hFFF));

    setup(3'd1, 16'h4000);
    for (int i = 0; i < 8; i++) tick_chk($sformatf("square%0d", i), sq_exp[i % 4]);

    setup(3'd2, 16'h2000);
    for (int i = 0; i < 8; i++) tick_chk($sformatf("tri%0d", i), tri_exp[i]);

    setup(3'd3, 16'h1000);
    for (int i = 1; i <= 4; i++) tick_chk($sformatf("incchg%0d", i), 12'(i * 16'h100));
    phase_inc = 16'h2000;
    for (int i = 5; i <= 15; i++) tick_chk($sformatf("incchg%0d", i), 12'(i * 16'h100));
    tick_chk("incchg wrap", 12'h000);
    tick_chk("incchg new1", 12'h200);
    tick_chk("incchg new2", 12'h400);

    setup(3'd4, 16'h4000);
    for (int i = 0; i < 4; i++) tick_chk($sformatf("sine%0d", i), sin_exp[i]);

    dc_level = 12'h5A5;
    setup(3'd0, 16'h0000);
    tick_chk("dc", 12'h5A5);
    dc_level = 12'h0F0;
    tick_chk("dc live", 12'h0F0);
    dc_level = 12'h123;
    setup(3'd6, 16'h1234);
    tick_chk("reserved dc", 12'h123);

    setup(3'd3, 16'h0000);
    tick_chk("inc0 a", 12'h000);
    tick_chk("inc0 b", 12'h000);

    setup(3'd3, 16'h1000);
    tick_chk("en-race pre", 12'h100);
    tick = 1'b1;
    en   = 1'b0;
    @(negedge clk);
    tick = 1'b0;
    check("en-race vld+1", 32'(sample_valid), 32'd0);
    @(negedge clk);
    check("en-race vld+2", 32'(sample_valid), 32'd0);
    check("en-race hold", 32'(sample), 32'h100);
    en = 1'b1;
    tick_chk("en-race restart", 12'h100);

    setup(3'd3, 16'h1000);
    tick = 1'b1;
    @(negedge clk);
    check("b2b vld+1", 32'(sample_valid), 32'd0);
    @(negedge clk);
    tick = 1'b0;
    check("b2b vld a", 32'(sample_valid), 32'd1);
    check("b2b sample a", 32'(sample), 32'h100);
    @(negedge clk);
    check("b2b vld b", 32'(sample_valid), 32'd1);
    check("b2b sample b", 32'(sample), 32'h200);
    @(negedge clk);
    check("b2b vld end", 32'(sample_valid), 32'd0);

    dc_level = 12'h3C3;
    setup(3'd3, 16'h1000);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    rst  = 1'b1;
    #1;
    check("midrst sample", 32'(sample), 32'd0);
    check("midrst valid", 32'(sample_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst vld+2", 32'(sample_valid), 32'd0);
    @(negedge clk);
    check("midrst vld+3", 32'(sample_valid), 32'd0);
    check("midrst sample2", 32'(sample), 32'd0);
    tick_chk("postrst dc", 12'h3C3);
    setup(3'd3, 16'h1000);
    tick_chk("postrst saw", 12'h100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
